sipo_deserializer: RTL and testbench

//   Parametrised serial-in/parallel-out deserializer. Successor to the fixed 8-bit shifter.

---
 rtl/sipo_deserializer.sv | 75 +++++++
 tb/tb_sipo_deserializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles WIDTH enabled serial bits into a word
// and publishes it in a holding register with valid/ready, bit counter and sticky overflow.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH)
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_SDI,
    input  logic             i_SFT,
    input  logic             i_CLR,
    input  logic             i_READY,
    output logic [WIDTH-1:0] o_OUT,
    output logic             o_VALID,
    output logic             o_OVF,
    output logic [CNT_W-1:0] o_CNT,
    output logic             o_BUSY
);

    // Handshake: a word transfers on any edge where o_VALID=1 and i_READY=1.
    // o_VALID never depends combinationally on i_READY; o_OUT is stable until the
    // next completion, i_CLR or reset, even after it has been consumed.

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CNT_W-1:0] cnt;
    logic             done;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_next = {sh[WIDTH-2:0], i_SDI};
        end else begin : g_lsb
            assign sh_next = {i_SDI, sh[WIDTH-1:1]};
        end
    endgenerate

    // The completing bit goes straight from sh_next into o_OUT, so no dead cycle.
    assign done   = i_SFT && (cnt == LAST);
    assign o_CNT  = cnt;
    assign o_BUSY = (cnt != '0);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sh      <= '0;
            cnt     <= '0;
            o_OUT   <= '0;
            o_VALID <= 1'b0;
            o_OVF   <= 1'b0;
        end else if (i_CLR) begin
            sh      <= '0;
            cnt     <= '0;
            o_OUT   <= '0;
            o_VALID <= 1'b0;
            o_OVF   <= 1'b0;
        end else begin
            if (i_SFT) begin
                sh  <= sh_next;
                cnt <= done ? '0 : cnt + 1'b1;
            end
            if (done) begin
                o_OUT   <= sh_next;
                o_VALID <= 1'b1;
                if (o_VALID && !i_READY) begin
                    o_OVF <= 1'b1;
                end
            end else if (o_VALID && i_READY) begin
                o_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: three instances (8/MSB, 8/LSB, 12/MSB) share one stimulus
// stream; a bit-list reference model feeds per-instance word queues and status checks.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sdi = 1'b0;
    logic sft = 1'b0;
    logic clr = 1'b0;
    logic rdy = 1'b0;

    logic [7:0]  out0, out1;
    logic [11:0] out2;
    logic        valid0, valid1, valid2;
    logic        ovf0, ovf1, ovf2;
    logic [2:0]  cnt0, cnt1;
    logic [3:0]  cnt2;
    logic        busy0, busy1, busy2;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SDI(sdi), .i_SFT(sft), .i_CLR(clr), .i_READY(rdy),
        .o_OUT(out0), .o_VALID(valid0), .o_OVF(ovf0), .o_CNT(cnt0), .o_BUSY(busy0));
    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SDI(sdi), .i_SFT(sft), .i_CLR(clr), .i_READY(rdy),
        .o_OUT(out1), .o_VALID(valid1), .o_OVF(ovf1), .o_CNT(cnt1), .o_BUSY(busy1));
    sipo_deserializer #(.WIDTH(12), .MSB_FIRST(1'b1)) u2 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SDI(sdi), .i_SFT(sft), .i_CLR(clr), .i_READY(rdy),
        .o_OUT(out2), .o_VALID(valid2), .o_OVF(ovf2), .o_CNT(cnt2), .o_BUSY(busy2));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- unified views of the three instances ----------------
    logic [11:0] a_out[3];
    logic [3:0]  a_cnt[3];
    logic        a_valid[3], a_ovf[3], a_busy[3];
    always_comb begin
        a_out[0] = {4'b0, out0};  a_out[1] = {4'b0, out1};  a_out[2] = out2;
        a_cnt[0] = {1'b0, cnt0};  a_cnt[1] = {1'b0, cnt1};  a_cnt[2] = cnt2;
        a_valid[0] = valid0; a_valid[1] = valid1; a_valid[2] = valid2;
        a_ovf[0] = ovf0;     a_ovf[1] = ovf1;     a_ovf[2] = ovf2;
        a_busy[0] = busy0;   a_busy[1] = busy1;   a_busy[2] = busy2;
    end

    function automatic int wd(int i);
        return (i == 2) ? 12 : 8;
    endfunction

    function automatic bit msb(int i);
        return (i != 1);
    endfunction

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic [11:0] exp_q2[$];

    task automatic chk(input string name, input int i, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    // ---------------- reference model: list of received bits per instance ----------------
    int          m_n[3];
    logic        m_bits[3][12];
    logic [11:0] m_out[3];
    logic        m_valid[3], m_ovf[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0; m_out[i] = '0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
        end
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            logic [11:0] w;
            bit          completed;
            w = '0;
            completed = 0;
            if (clr) begin
                m_n[i] = 0; m_out[i] = '0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
                if (sft) begin
                    m_bits[i][m_n[i]] = sdi;
                    m_n[i]++;
                    if (m_n[i] == wd(i)) begin
                        for (int k = 0; k < wd(i); k++) begin
                            if (msb(i)) w[wd(i)-1-k] = m_bits[i][k];
                            else        w[k] = m_bits[i][k];
                        end
                        m_n[i] = 0;
                        completed = 1;
                    end
                end
                if (completed) begin
                    if (m_valid[i] && !rdy) m_ovf[i] = 1'b1;
                    m_out[i] = w;
                    m_valid[i] = 1'b1;
                    case (i)
                        0: exp_q0.push_back(w);
                        1: exp_q1.push_back(w);
                        default: exp_q2.push_back(w);
                    endcase
                end else if (m_valid[i] && rdy) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_status();
        for (int i = 0; i < 3; i++) begin
            chk("cnt", i, {8'b0, a_cnt[i]}, 12'(m_n[i]));
            chk("valid", i, {11'b0, a_valid[i]}, {11'b0, m_valid[i]});
            chk("ovf", i, {11'b0, a_ovf[i]}, {11'b0, m_ovf[i]});
            chk("busy", i, {11'b0, a_busy[i]}, {11'b0, (m_n[i] != 0)});
            chk("out", i, a_out[i], m_out[i]);
        end
    endtask

    // ---------------- monitor: pops a word whenever a new one is presented ----------------
    logic       p_valid[3];
    logic [3:0] p_cnt[3];
    initial for (int i = 0; i < 3; i++) begin p_valid[i] = 1'b0; p_cnt[i] = '0; end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                p_valid[i] = 1'b0; p_cnt[i] = '0;
            end else begin
                if (a_valid[i] && (!p_valid[i] || (p_cnt[i] == 4'(wd(i) - 1) && a_cnt[i] == 0))) begin
                    logic [11:0] e;
                    bit          empty;
                    empty = 0; e = '0;
                    case (i)
                        0: if (exp_q0.size() == 0) empty = 1; else e = exp_q0.pop_front();
                        1: if (exp_q1.size() == 0) empty = 1; else e = exp_q1.pop_front();
                        default: if (exp_q2.size() == 0) empty = 1; else e = exp_q2.pop_front();
                    endcase
                    if (empty) begin
                        checks++; errors++;
                        $display("FAIL word_unexpected inst%0d: got %h expected none at %0t", i, a_out[i], $time);
                    end else begin
                        chk("word", i, a_out[i], e);
                    end
                end
                p_valid[i] = a_valid[i];
                p_cnt[i] = a_cnt[i];
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic s, input logic d, input logic c, input logic r);
        sft = s; sdi = d; clr = c; rdy = r;
        @(posedge clk);
        model_edge();
        #1;
        check_status();
    endtask

    task automatic send8(input logic [7:0] b, input int max_gap, input bit rdy_last);
        for (int k = 7; k >= 0; k--) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
            for (int j = 0; j < g; j++) step(1'b0, 1'($urandom), 1'b0, 1'b0);
            step(1'b1, b[k], 1'b0, (rdy_last && k == 0));
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_status();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_status();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 8-bit stream 1,0,1,1,0,0,1,0 with no consumer
        send8(8'hB2, 0, 0);
        chk("t1_msb_word", 0, a_out[0], 12'h0B2);
        chk("t1_lsb_word", 1, a_out[1], 12'h04D);
        chk("t1_valid", 0, {11'b0, a_valid[0]}, 12'h001);
        chk("t1_cnt", 0, {8'b0, a_cnt[0]}, 12'h000);

        // same stream with idle gaps
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send8(8'hB2, 3, 0);
        chk("t2_lsb_gap_word", 1, a_out[1], 12'h04D);

        // overflow: second word while first unconsumed, then clear
        send8(8'h0F, 0, 0);
        chk("t3_ovf_word", 0, a_out[0], 12'h00F);
        chk("t3_ovf", 0, {11'b0, a_ovf[0]}, 12'h001);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_clr_out", 0, a_out[0], 12'h000);

        // transfer coincident with completion
        send8(8'h3C, 0, 0);
        send8(8'h96, 0, 1);
        chk("t4_word2", 0, a_out[0], 12'h096);
        chk("t4_valid", 0, {11'b0, a_valid[0]}, 12'h001);
        chk("t4_ovf", 0, {11'b0, a_ovf[0]}, 12'h000);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_consumed", 0, {11'b0, a_valid[0]}, 12'h000);

        // clear mid-word drops the concurrent bit
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_cnt", 0, {8'b0, a_cnt[0]}, 12'h000);
        send8(8'hA5, 0, 0);
        chk("t5_word", 0, a_out[0], 12'h0A5);

        // asynchronous reset between edges with a partial word pending
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send8(8'h5A, 0, 0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        chk("t6_cnt_pre", 0, {8'b0, a_cnt[0]}, 12'h005);
        #2;
        apply_reset();
        send8(8'hC3, 0, 0);
        chk("t6_word", 0, a_out[0], 12'h0C3);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom_range(9, 0) < 7), 1'($urandom), 1'($urandom_range(49, 0) == 0),
                 1'($urandom_range(9, 0) < 4));
        end

        // drain the monitor and confirm every issued word was presented
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("q0_empty", 0, 12'(exp_q0.size()), 12'h000);
        chk("q1_empty", 1, 12'(exp_q1.size()), 12'h000);
        chk("q2_empty", 2, 12'(exp_q2.size()), 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
